// File: rtl/led_out_pkg.sv
// Shared types and code-to-duty mapping for the four-channel LED PWM driver.
package led_out_pkg;

  typedef enum logic {
    HEARTBEAT = 1'b0,
    ACTIVE    = 1'b1
  } led_state_e;

  // Duty expressed in quarters of the PWM period (compared against a 2-bit phase).
  localparam logic [2:0] DUTY_CODE_00 = 3'd0;
  localparam logic [2:0] DUTY_CODE_01 = 3'd1;
  localparam logic [2:0] DUTY_CODE_10 = 3'd2;
  localparam logic [2:0] DUTY_CODE_11 = 3'd4;

  function automatic logic [2:0] code_to_duty(input logic [1:0] code);
    logic [2:0] duty;
    case (code)
      2'b00:   duty = DUTY_CODE_00;
      2'b01:   duty = DUTY_CODE_01;
      2'b10:   duty = DUTY_CODE_10;
      2'b11:   duty = DUTY_CODE_11;
      default: duty = DUTY_CODE_00;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED: holds its 2-bit brightness code and registers the PWM compare
// (or the heartbeat bit when the driver is not in ACTIVE).
module led_pwm_channel
  import led_out_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       we,
  input  logic [1:0] code_in,
  input  logic [1:0] phase,
  input  logic       pwm_en,
  input  logic       hb,
  output logic       led
);

  logic [1:0] code_r;
  logic       led_r;
  logic       led_s;

  always_comb begin
    led_s = 1'b0;
    if (pwm_en) begin
      led_s = ({1'b0, phase} < code_to_duty(code_r));
    end else begin
      led_s = hb;
    end
  end

  // Code capture and registered LED drive.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      code_r <= 2'b00;
      led_r  <= 1'b0;
    end else begin
      if (we) begin
        code_r <= code_in;
      end else begin
        code_r <= code_r;
      end
      led_r <= led_s;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_pwm_out.sv
// Four-LED PWM driver with a write watchdog; falls back to a heartbeat blink on
// LED0 when the SoC stops writing.
module led_pwm_out
  import led_out_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int TIMEOUT_W  = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] led_in,
  input  logic       led_we,
  output logic [3:0] led_out,
  output logic       active
);

  logic [PRESCALE_W-1:0] prescale_r;
  logic [1:0]            phase_r;
  logic [TIMEOUT_W-1:0]  wd_r;
  logic [TIMEOUT_W-1:0]  wd_next_s;
  logic                  hb_r;
  logic                  hb_next_s;
  led_state_e            state_r;
  led_state_e            state_next_s;
  logic                  active_r;
  logic                  tick_s;

  assign tick_s = &prescale_r;

  // Watchdog doubles as the heartbeat timebase; a write always wins over expiry.
  always_comb begin
    state_next_s = state_r;
    wd_next_s    = wd_r + TIMEOUT_W'(1'b1);
    hb_next_s    = hb_r;
    case (state_r)
      HEARTBEAT: begin
        if (led_we) begin
          state_next_s = ACTIVE;
          wd_next_s    = {TIMEOUT_W{1'b0}};
        end else if (&wd_r) begin
          hb_next_s = ~hb_r;
        end else begin
          hb_next_s = hb_r;
        end
      end
      ACTIVE: begin
        if (led_we) begin
          wd_next_s = {TIMEOUT_W{1'b0}};
        end else if (&wd_r) begin
          state_next_s = HEARTBEAT;
          wd_next_s    = {TIMEOUT_W{1'b0}};
          hb_next_s    = 1'b0;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = HEARTBEAT;
        wd_next_s    = {TIMEOUT_W{1'b0}};
        hb_next_s    = 1'b0;
      end
    endcase
  end

  // Shared timebase, watchdog and FSM state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescale_r <= {PRESCALE_W{1'b0}};
      phase_r    <= 2'b00;
      wd_r       <= {TIMEOUT_W{1'b0}};
      hb_r       <= 1'b0;
      state_r    <= HEARTBEAT;
      active_r   <= 1'b0;
    end else begin
      prescale_r <= prescale_r + PRESCALE_W'(1'b1);
      if (tick_s) begin
        phase_r <= phase_r + 2'd1;
      end else begin
        phase_r <= phase_r;
      end
      wd_r     <= wd_next_s;
      hb_r     <= hb_next_s;
      state_r  <= state_next_s;
      active_r <= (state_next_s == ACTIVE);
    end
  end

  assign active = active_r;

  for (genvar k = 0; k < 4; k++) begin : g_chan
    led_pwm_channel u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .we      (led_we),
      .code_in (led_in[2*k+1 -: 2]),
      .phase   (phase_r),
      .pwm_en  (state_r == ACTIVE),
      .hb      ((k == 0) ? hb_r : 1'b0),
      .led     (led_out[k])
    );
  end

endmodule

// File: tb/tb_led_pwm_out.sv
// Directed bench for led_pwm_out with PRESCALE_W=2 (16-cycle period), TIMEOUT_W=6.
module tb_led_pwm_out;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] led_in;
  logic       led_we;
  logic [3:0] led_out;
  logic       active;

  int tests_run    = 0;
  int tests_failed = 0;

  led_pwm_out #(.PRESCALE_W(2), .TIMEOUT_W(6)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .led_in  (led_in),
    .led_we  (led_we),
    .led_out (led_out),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_code(input logic [7:0] v);
    led_in = v;
    led_we = 1'b1;
    tick();
    led_we = 1'b0;
  endtask

  task automatic test_reset();
    int rise;
    int fall;
    int hi_bad;
    resetn = 1'b0;
    led_we = 1'b1;
    led_in = 8'hFF;
    repeat (3) tick();
    tests_run++;
    if (led_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_led_out: got %h expected %h", led_out, 4'h0);
    end
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_active: got %b expected %b", active, 1'b0);
    end
    led_we = 1'b0;
    resetn = 1'b1;
    rise = -1;
    fall = -1;
    hi_bad = 0;
    for (int i = 1; i <= 140; i++) begin
      tick();
      if (led_out[3:1] !== 3'b000) hi_bad++;
      if (rise < 0 && led_out[0] === 1'b1) rise = i;
      else if (rise >= 0 && fall < 0 && led_out[0] === 1'b0) fall = i;
    end
    tests_run++;
    if (rise !== 65) begin
      tests_failed++;
      $display("FAIL hb_first_rise: got %0d expected %0d", rise, 65);
    end
    tests_run++;
    if (fall !== 129) begin
      tests_failed++;
      $display("FAIL hb_first_fall: got %0d expected %0d", fall, 129);
    end
    tests_run++;
    if (hi_bad !== 0) begin
      tests_failed++;
      $display("FAIL hb_upper_leds: got %0d lit cycles expected %0d", hi_bad, 0);
    end
  endtask

  task automatic test_full_on();
    int bad;
    write_code(8'hFF);
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_active: got %b expected %b", active, 1'b1);
    end
    tests_run++;
    if (led_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL full_latency_n1: got %h expected %h", led_out, 4'h0);
    end
    tick();
    tests_run++;
    if (led_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL full_n2: got %h expected %h", led_out, 4'hF);
    end
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (led_out !== 4'hF) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL full_constant: got %0d bad cycles expected %0d", bad, 0);
    end
  endtask

  task automatic test_duty();
    int hi [4];
    int exp_hi [4];
    exp_hi = '{16, 8, 4, 0};
    for (int k = 0; k < 4; k++) hi[k] = 0;
    write_code(8'h1B);
    tests_run++;
    if (led_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL duty_old_code_n1: got %h expected %h", led_out, 4'hF);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) if (led_out[k] === 1'b1) hi[k]++;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (hi[k] !== exp_hi[k]) begin
        tests_failed++;
        $display("FAIL duty_led%0d: got %0d high cycles expected %0d", k, hi[k], exp_hi[k]);
      end
    end
  endtask

  task automatic test_timeout();
    write_code(8'h1B);
    repeat (63) tick();
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_before: got %b expected %b", active, 1'b1);
    end
    tick();
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_expired: got %b expected %b", active, 1'b0);
    end
    tick();
    tests_run++;
    if (led_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL timeout_hb_start: got %h expected %h", led_out, 4'h0);
    end
    repeat (63) tick();
    tests_run++;
    if (led_out !== 4'h0) begin
      tests_failed++;
      $display("FAIL timeout_hb_pre_toggle: got %h expected %h", led_out, 4'h0);
    end
    tick();
    tests_run++;
    if (led_out !== 4'h1) begin
      tests_failed++;
      $display("FAIL timeout_hb_toggle: got %h expected %h", led_out, 4'h1);
    end
  endtask

  task automatic test_expiry_write();
    write_code(8'hFF);
    repeat (63) tick();
    write_code(8'hFF);
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL expiry_write_wins: got %b expected %b", active, 1'b1);
    end
    repeat (63) tick();
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL expiry_rearmed: got %b expected %b", active, 1'b1);
    end
    tick();
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL expiry_second_timeout: got %b expected %b", active, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    write_code(8'hFF);
    repeat (5) tick();
    tests_run++;
    if (led_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: got %h expected %h", led_out, 4'hF);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tests_run++;
    if (led_out !== 4'h0 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got led_out=%h active=%b expected led_out=%h active=%b",
               led_out, active, 4'h0, 1'b0);
    end
    repeat (3) tick();
    tests_run++;
    if (led_out !== 4'h0 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_after_release: got led_out=%h active=%b expected led_out=%h active=%b",
               led_out, active, 4'h0, 1'b0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    led_we = 1'b0;
    led_in = 8'h00;
    test_reset();
    test_full_on();
    test_duty();
    test_timeout();
    test_expiry_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
